// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg
//   Shared constants and types for the IF stage (if_fetch_unit and its
//   fetch queue).
//   - NOP_INSTR  : instruction word presented when IF2ID holds no instruction
//   - PC_STEP    : sequential fetch increment
//   - fq_entry_t : one fetch-queue slot {pc, instr, filled}
//   - word_align : clears the two low address bits
// ---------------------------------------------------------------------------
package if_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//   Circular queue of outstanding fetches. A slot is allocated when a request
//   is accepted, filled (in order) when its response returns, and popped into
//   IF2ID. Flush empties the queue in one cycle.
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     flush_i           drop every entry (redirect)
//     alloc_i/_pc_i     allocate a slot for a newly accepted request
//     fill_i/_instr_i   fill the oldest unfilled slot
//     pop_i             consume the head (only taken when head_vld_o)
//     head_vld_o        head is filled, or is being filled this cycle
//     head_pc_o/_instr_o head contents (instr bypassed from fill_instr_i)
//     entries_o         allocated slots
//     unfilled_o        allocated slots still waiting for their response
// ---------------------------------------------------------------------------
module if_fetch_queue
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          alloc_i,
  input  logic [31:0]   alloc_pc_i,
  input  logic          fill_i,
  input  logic [31:0]   fill_instr_i,
  input  logic          pop_i,
  output logic          head_vld_o,
  output logic [31:0]   head_pc_o,
  output logic [31:0]   head_instr_o,
  output logic [CW-1:0] entries_o,
  output logic [CW-1:0] unfilled_o
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [CW-1:0] head_q, fill_q, tail_q;
  logic [CW-1:0] head_d, fill_d, tail_d;
  fq_entry_t     ent_q [DEPTH];

  logic [AW-1:0] head_idx, fill_idx, tail_idx;
  logic          head_filled, bypass;
  logic          alloc_ok, fill_ok, pop_ok;

  assign head_idx   = head_q[AW-1:0];
  assign fill_idx   = fill_q[AW-1:0];
  assign tail_idx   = tail_q[AW-1:0];

  assign entries_o  = tail_q - head_q;
  assign unfilled_o = tail_q - fill_q;

  assign alloc_ok   = alloc_i && (entries_o != FULL);
  assign fill_ok    = fill_i && (unfilled_o != '0);

  // A response filling the head slot is forwarded in the same cycle, so a
  // response arriving in cycle T can reach IF2ID at T+1.
  assign head_filled  = (entries_o != '0) && ent_q[head_idx].filled;
  assign bypass       = fill_ok && (fill_q == head_q);
  assign head_vld_o   = head_filled || bypass;
  assign head_pc_o    = ent_q[head_idx].pc;
  assign head_instr_o = head_filled ? ent_q[head_idx].instr : fill_instr_i;

  assign pop_ok = pop_i && head_vld_o;

  always_comb begin
    head_d = head_q;
    fill_d = fill_q;
    tail_d = tail_q;
    if (flush_i) begin
      head_d = '0;
      fill_d = '0;
      tail_d = '0;
    end else begin
      if (alloc_ok) tail_d = tail_q + CW'(1);
      if (fill_ok)  fill_d = fill_q + CW'(1);
      if (pop_ok)   head_d = head_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '{pc: 32'h0, instr: NOP_INSTR, filled: 1'b0};
      end
    end else begin
      head_q <= head_d;
      fill_q <= fill_d;
      tail_q <= tail_d;
      if (!flush_i) begin
        // Alloc and fill never target the same slot: that would need
        // unfilled == 0, which disables the fill.
        if (alloc_ok) begin
          ent_q[tail_idx] <= '{pc: alloc_pc_i, instr: NOP_INSTR, filled: 1'b0};
        end
        if (fill_ok) begin
          ent_q[fill_idx].instr  <= fill_instr_i;
          ent_q[fill_idx].filled <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   IF stage. Owns the fetch PC, issues in-order word fetches to instruction
//   memory, queues the responses and presents {pc, instr} to IF2ID.
//   A redirect flushes the queue; responses to requests still in flight at
//   that point are counted in drop_cnt and discarded when they return.
//   Optional build macro IF_MISALIGN_CHK_EN adds IF_misalign: a redirect to a
//   non word-aligned target sets it and stops fetching until the next
//   redirect. Without the macro the target's low two bits are ignored.
//   Ports:
//     clk, rst_n                        clock, async active-low reset
//     hold_IF                           stall IF2ID (issue/fill continue)
//     CTRL_IF_jmp_vld/CTRL_IF_jmp_addr  redirect request and target
//     imem_req_vld/_rdy/_addr           request channel; transfer on vld&&rdy.
//                                       vld is withdrawn in a redirect cycle
//                                       even without a transfer.
//     imem_rsp_vld/_data                in-order responses, no backpressure
//     IF_ID_vld/_pc/_instr              IF2ID register (instr=NOP when !vld)
//     IF_misalign                       (IF_MISALIGN_CHK_EN only)
// ---------------------------------------------------------------------------
module if_fetch_unit
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_IF,
  input  logic        CTRL_IF_jmp_vld,
  input  logic [31:0] CTRL_IF_jmp_addr,
  output logic        imem_req_vld,
  input  logic        imem_req_rdy,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_vld,
  input  logic [31:0] imem_rsp_data,
`ifdef IF_MISALIGN_CHK_EN
  output logic        IF_misalign,
`endif
  output logic        IF_ID_vld,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_instr
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          if_vld_q, if_vld_d;
  logic [31:0]   if_pc_q, if_pc_d;
  logic [31:0]   if_instr_q, if_instr_d;

  logic          redirect, fetch_blocked, req_hs, rsp_fill, if_update, pop;
  logic [CW-1:0] entries, unfilled;
  logic [CW:0]   occupancy;
  logic          head_vld;
  logic [31:0]   head_pc, head_instr;

  assign redirect = CTRL_IF_jmp_vld;

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        misalign_q <= 1'b0;
    else if (redirect) misalign_q <= (CTRL_IF_jmp_addr[1:0] != 2'b00);
  end
  assign fetch_blocked = misalign_q;
  assign IF_misalign   = misalign_q;
`else
  assign fetch_blocked = 1'b0;
`endif

  // Every request in flight is either a queue entry or a pending drop, so
  // capping their sum also caps the memory's outstanding requests.
  assign occupancy = {1'b0, entries} + {1'b0, drop_cnt_q};

  // rst_n gating keeps the request deasserted while reset is held.
  assign imem_req_vld  = rst_n && !redirect && !fetch_blocked &&
                         (occupancy < (CW+1)'(QUEUE_DEPTH));
  assign imem_req_addr = fetch_pc_q;
  assign req_hs        = imem_req_vld && imem_req_rdy;

  // Responses belong to live entries only once every stale one has drained;
  // one arriving in a redirect cycle belongs to a flushed entry.
  assign rsp_fill  = imem_rsp_vld && (drop_cnt_q == '0) && !redirect;
  assign if_update = !hold_IF && !redirect;
  assign pop       = if_update && head_vld;

  if_fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .CW    (CW)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect),
    .alloc_i      (req_hs),
    .alloc_pc_i   (fetch_pc_q),
    .fill_i       (rsp_fill),
    .fill_instr_i (imem_rsp_data),
    .pop_i        (pop),
    .head_vld_o   (head_vld),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr),
    .entries_o    (entries),
    .unfilled_o   (unfilled)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect)    fetch_pc_d = word_align(CTRL_IF_jmp_addr);
    else if (req_hs) fetch_pc_d = fetch_pc_q + PC_STEP;  // wraps to 0
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (redirect) begin
      // Unfilled entries become stale; a response in this very cycle is
      // already one of them (or a stale one) and is consumed now.
      drop_cnt_d = drop_cnt_q + unfilled - {{(CW-1){1'b0}}, imem_rsp_vld};
    end else if (imem_rsp_vld && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_comb begin
    if_vld_d   = if_vld_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if (redirect) begin
      if_vld_d   = 1'b0;
      if_instr_d = NOP_INSTR;
    end else if (if_update) begin
      if (head_vld) begin
        if_vld_d   = 1'b1;
        if_pc_d    = head_pc;
        if_instr_d = head_instr;
      end else begin
        if_vld_d   = 1'b0;
        if_instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
      if_vld_q   <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= NOP_INSTR;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
      if_vld_q   <= if_vld_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign IF_ID_vld   = if_vld_q;
  assign IF_ID_pc    = if_pc_q;
  assign IF_ID_instr = if_instr_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//   Drives if_fetch_unit against a behavioural in-order instruction memory
//   with programmable latency. Every accepted request pushes its pc onto
//   exp_q; a live response marks the oldest waiting entry as arrived; every
//   IF2ID update pops and compares. Redirects flush exp_q and mark the
//   memory's in-flight responses stale.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam int          QD  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        hold_IF, CTRL_IF_jmp_vld, imem_req_rdy, imem_rsp_vld;
  logic [31:0] CTRL_IF_jmp_addr, imem_rsp_data;
  logic        imem_req_vld, IF_ID_vld;
  logic [31:0] imem_req_addr, IF_ID_pc, IF_ID_instr;
`ifdef IF_MISALIGN_CHK_EN
  logic        IF_misalign;
`endif

  if_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .hold_IF          (hold_IF),
    .CTRL_IF_jmp_vld  (CTRL_IF_jmp_vld),
    .CTRL_IF_jmp_addr (CTRL_IF_jmp_addr),
    .imem_req_vld     (imem_req_vld),
    .imem_req_rdy     (imem_req_rdy),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_vld     (imem_rsp_vld),
    .imem_rsp_data    (imem_rsp_data),
`ifdef IF_MISALIGN_CHK_EN
    .IF_misalign      (IF_misalign),
`endif
    .IF_ID_vld        (IF_ID_vld),
    .IF_ID_pc         (IF_ID_pc),
    .IF_ID_instr      (IF_ID_instr)
  );

  // ---------------- scoreboard / model state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } mem_t;

  mem_t        mem_q[$];
  logic [32:0] exp_q[$];   // {arrived, pc}
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  int          mem_lat  = 1;
  logic [31:0] mdl_pc       = 32'h0;
  logic [31:0] mdl_if_pc    = 32'h0;
  logic [31:0] mdl_if_instr = NOP;
  bit          mdl_vld = 1'b0;
  bit          mdl_mis = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Entered #1 after a rising edge; returns #1 after the next one.
  task automatic cycle(input bit hold, input bit jmp, input logic [31:0] jaddr, input bit rdy);
    int          stale;
    bit          hs;
    bit          exp_req;
    mem_t        m;
    logic [32:0] e;
    hold_IF          = hold;
    CTRL_IF_jmp_vld  = jmp;
    CTRL_IF_jmp_addr = jaddr;
    imem_req_rdy     = rdy;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_vld  = 1'b1;
      imem_rsp_data = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_vld  = 1'b0;
      imem_rsp_data = $urandom;
    end
    #1;
    stale = 0;
    foreach (mem_q[i]) if (!mem_q[i].live) stale++;
    exp_req = !jmp && !mdl_mis && ((exp_q.size() + stale) < QD);
    check("req_vld", {31'b0, imem_req_vld}, {31'b0, exp_req});
    hs = imem_req_vld && rdy;
    if (hs) check("req_addr", imem_req_addr, mdl_pc);

    if (imem_rsp_vld) begin
      m = mem_q.pop_front();
      if (m.live && !jmp) begin
        for (int i = 0; i < exp_q.size(); i++) begin
          if (!exp_q[i][32]) begin
            e = exp_q[i]; e[32] = 1'b1; exp_q[i] = e;
            break;
          end
        end
      end
    end

    if (jmp) begin
      mdl_vld      = 1'b0;
      mdl_if_instr = NOP;
    end else if (!hold) begin
      if (exp_q.size() > 0 && exp_q[0][32]) begin
        e            = exp_q.pop_front();
        mdl_vld      = 1'b1;
        mdl_if_pc    = e[31:0];
        mdl_if_instr = mem_word(e[31:0]);
      end else begin
        mdl_vld      = 1'b0;
        mdl_if_instr = NOP;
      end
    end

    if (hs) begin
      mem_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat, live: 1'b1});
      exp_q.push_back({1'b0, mdl_pc});
      mdl_pc = mdl_pc + 32'd4;
    end

    if (jmp) begin
      exp_q.delete();
      for (int i = 0; i < mem_q.size(); i++) begin
        m = mem_q[i]; m.live = 1'b0; mem_q[i] = m;
      end
      mdl_pc = {jaddr[31:2], 2'b00};
`ifdef IF_MISALIGN_CHK_EN
      mdl_mis = (jaddr[1:0] != 2'b00);
`endif
    end

    @(posedge clk);
    #1;
    cyc++;
    check("if_vld", {31'b0, IF_ID_vld}, {31'b0, mdl_vld});
    check("if_instr", IF_ID_instr, mdl_if_instr);
    if (mdl_vld) check("if_pc", IF_ID_pc, mdl_if_pc);
    check("in_flight_le_depth", {31'b0, (mem_q.size() <= QD)}, 32'd1);
`ifdef IF_MISALIGN_CHK_EN
    check("misalign", {31'b0, IF_misalign}, {31'b0, mdl_mis});
`endif
  endtask

  task automatic run(input int n, input bit hold, input bit rdy);
    for (int i = 0; i < n; i++) cycle(hold, 1'b0, 32'h0, rdy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ja;
    rst_n            = 1'b0;
    hold_IF          = 1'b0;
    CTRL_IF_jmp_vld  = 1'b0;
    CTRL_IF_jmp_addr = 32'h0;
    imem_req_rdy     = 1'b0;
    imem_rsp_vld     = 1'b0;
    imem_rsp_data    = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_if_vld", {31'b0, IF_ID_vld}, 32'd0);
    check("rst_if_pc", IF_ID_pc, 32'h0);
    check("rst_if_instr", IF_ID_instr, NOP);
    check("rst_req_vld", {31'b0, imem_req_vld}, 32'd0);
    rst_n = 1'b1;

    // Streaming with a 1-cycle memory: IF_ID pc 0,4,8 on consecutive cycles.
    mem_lat = 1;
    run(4, 1'b0, 1'b1);
    // Hold with IF_ID_pc=8: IF2ID frozen, queue fills up and issue stalls.
    run(3, 1'b1, 1'b1);
    run(4, 1'b1, 1'b1);
    run(6, 1'b0, 1'b1);

    // Redirect with requests in flight on a 3-cycle memory.
    mem_lat = 3;
    run(5, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    run(12, 1'b0, 1'b1);

    // Redirect coinciding with a response and with hold_IF asserted.
    run(2, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0040, 1'b1);
    run(10, 1'b0, 1'b1);

    // Address wrap.
    mem_lat = 1;
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    run(6, 1'b0, 1'b1);

    // Back-to-back redirects: the last one wins.
    cycle(1'b0, 1'b1, 32'h0000_0500, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0800, 1'b1);
    run(6, 1'b0, 1'b1);

`ifdef IF_MISALIGN_CHK_EN
    cycle(1'b0, 1'b1, 32'h0000_0102, 1'b1);
    run(5, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    run(5, 1'b0, 1'b1);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) mem_lat = $urandom_range(1, 4);
      ja = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
`ifdef IF_MISALIGN_CHK_EN
      if ($urandom_range(0, 7) == 0) ja[1:0] = 2'($urandom_range(1, 3));
`endif
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, ja,
            $urandom_range(0, 9) < 7);
    end

    // Drain: no new requests, everything accepted must come out.
`ifdef IF_MISALIGN_CHK_EN
    cycle(1'b0, 1'b1, 32'h0000_0300, 1'b1);
`endif
    run(30, 1'b0, 1'b0);
    check("drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
